mem_access_unit: RTL and testbench

//  Sequencer between the multi-cycle controller/datapath and the unified instruction/data mem.

---
 rtl/mem_access_unit.sv | 132 +++++++++++++
 tb/tb_mem_access_unit.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// Load/store sequencer between the multi-cycle core and a unified async-read memory.
// Optional misalignment trapping is compiled in with `define MEM_MISALIGN_CHECK_EN.
module mem_access_unit #(
  parameter bit BIG_ENDIAN = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wd,
  input  logic [31:0] mem_rd
);

  typedef enum logic [2:0] {IDLE, LOAD, STORE, RMW_RD, RMW_WR, RESP} state_t;

  state_t      state, state_next;
  logic [31:0] addr_q, wdata_q, merge_q;
  logic [1:0]  size_q;
  logic        signed_q;
  logic        accept, misaligned;
  logic [1:0]  byte_lane;
  logic        half_lane;
  logic [7:0]  byte_val;
  logic [15:0] half_val;
  logic [31:0] load_data, merged;

  assign accept = req_valid && req_ready;

`ifdef MEM_MISALIGN_CHECK_EN
  logic err_q;

  assign misaligned = ((req_size == 2'b01) && req_addr[0]) ||
                      (req_size[1] && (req_addr[1:0] != 2'b00));

  always_ff @(posedge clk or posedge reset) begin
    if (reset)       err_q <= 1'b0;
    else if (accept) err_q <= misaligned;
  end

  assign resp_err = (state == RESP) && err_q;
`else
  // Without trapping, the lane logic simply ignores address bits below the access size.
  assign misaligned = 1'b0;
  assign resp_err   = 1'b0;
`endif

  // Big-endian lane k is 3-k, which for a 2-bit index is its bitwise inverse.
  assign byte_lane = BIG_ENDIAN ? ~addr_q[1:0] : addr_q[1:0];
  assign half_lane = BIG_ENDIAN ? ~addr_q[1]   : addr_q[1];
  assign byte_val  = mem_rd[{byte_lane, 3'b000} +: 8];
  assign half_val  = mem_rd[{half_lane, 4'b0000} +: 16];

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    load_data = mem_rd;
    merged    = merge_q;
    case (size_q)
      2'b00: begin
        load_data = {{24{signed_q & byte_val[7]}}, byte_val};
        merged[{byte_lane, 3'b000} +: 8] = wdata_q[7:0];
      end
      2'b01: begin
        load_data = {{16{signed_q & half_val[15]}}, half_val};
        merged[{half_lane, 4'b0000} +: 16] = wdata_q[15:0];
      end
      default: ;
    endcase
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (accept) begin
        if (misaligned)     state_next = RESP;
        else if (!req_we)   state_next = LOAD;
        else if (req_size[1]) state_next = STORE;
        else                state_next = RMW_RD;
      end
      LOAD, STORE, RMW_WR: state_next = RESP;
      RMW_RD:              state_next = RMW_WR;
      RESP:                state_next = IDLE;
      default:             state_next = IDLE;
    endcase
  end

  // Memory-side outputs decode from state alone, so reset drops mem_we immediately.
  assign req_ready  = (state == IDLE);
  assign resp_valid = (state == RESP);
  assign mem_we     = (state == STORE) || (state == RMW_WR);
  assign mem_addr   = {addr_q[31:2], 2'b00};
  assign mem_wd     = (state == STORE)  ? wdata_q :
                      (state == RMW_WR) ? merged  : 32'h0;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      merge_q    <= '0;
      size_q     <= '0;
      signed_q   <= 1'b0;
      resp_rdata <= '0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: if (accept) begin
          addr_q   <= req_addr;
          wdata_q  <= req_wdata;
          size_q   <= req_size;
          signed_q <= req_signed;
          if (misaligned) resp_rdata <= '0;
        end
        LOAD:          resp_rdata <= load_data;
        RMW_RD:        merge_q    <= mem_rd;
        STORE, RMW_WR: resp_rdata <= '0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed vectors plus randomized requests
// scored against a word-array reference model built from shift/mask arithmetic.
module tb_mem_access_unit;

  localparam bit BE = 1'b0;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_we, req_signed;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_err, mem_we;
  logic [31:0] resp_rdata, mem_addr, mem_wd, mem_rd;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem     [256];
  logic [31:0] ref_mem [256];
  logic        mem_init;

  mem_access_unit #(.BIG_ENDIAN(BE)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_size(req_size),
    .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wd(mem_wd), .mem_rd(mem_rd)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] pat(input int i);
    return (32'(i) * 32'h9E37_79B9) ^ 32'hA5C3_0F96;
  endfunction

  always @(posedge clk) begin
    if (mem_init) for (int i = 0; i < 256; i++) mem[i] <= pat(i);
    else if (mem_we) mem[mem_addr[9:2]] <= mem_wd;
  end
  assign mem_rd = mem[mem_addr[9:2]];

  // Reference model: expected response and memory effect of one request, applied at accept time.
  task automatic model(input logic we, input logic [1:0] size, input logic sgn,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       output logic [31:0] rdata, output logic err,
                       output int lat, output int we_cycles);
    int k, sh;
    logic [31:0] w, v, m;
    logic mis = 1'b0;
`ifdef MEM_MISALIGN_CHECK_EN
    mis = (size == 2'b01 && addr[0]) || (size[1] && addr[1:0] != 2'b00);
`endif
    k  = BE ? 3 - int'(addr[1:0]) : int'(addr[1:0]);
    sh = (size == 2'b00) ? 8 * k : 16 * (k / 2);
    m  = (size == 2'b00) ? (32'hFF << sh) : (32'hFFFF << sh);
    w  = ref_mem[addr[9:2]];
    rdata = 32'h0; err = 1'b0; we_cycles = 0;
    if (mis) begin
      err = 1'b1; lat = 1;
    end else if (!we) begin
      lat = 2;
      if (size[1]) rdata = w;
      else begin
        v = (w & m) >> sh;
        if (sgn && size == 2'b00 && v[7])  v = v | 32'hFFFF_FF00;
        if (sgn && size == 2'b01 && v[15]) v = v | 32'hFFFF_0000;
        rdata = v;
      end
    end else begin
      we_cycles = 1;
      if (size[1]) begin
        lat = 2; ref_mem[addr[9:2]] = wdata;
      end else begin
        lat = 3; ref_mem[addr[9:2]] = (w & ~m) | ((wdata << sh) & m);
      end
    end
  endtask

  task automatic run_req(input logic we, input logic [1:0] size, input logic sgn,
                         input logic [31:0] addr, input logic [31:0] wdata, input string name,
                         output logic [31:0] got_rdata, output logic got_err);
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat, exp_we, lat, we_cnt;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1) begin
      errors++; $display("FAIL %s ready: got %b expected 1", name, req_ready);
    end
    req_valid = 1'b1; req_we = we; req_size = size; req_signed = sgn;
    req_addr = addr; req_wdata = wdata;
    model(we, size, sgn, addr, wdata, exp_rdata, exp_err, exp_lat, exp_we);
    @(posedge clk); #1;
    req_valid = 1'b0; req_we = 1'($urandom); req_size = 2'($urandom);
    req_addr = $urandom; req_wdata = $urandom;
    lat = 0; we_cnt = 0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (mem_we === 1'b1) we_cnt++;
      if (resp_valid === 1'b1) begin lat = c; break; end
    end
    got_rdata = resp_rdata; got_err = resp_err;
    checks += 4;
    if (lat != exp_lat) begin
      errors++; $display("FAIL %s latency: got %0d expected %0d (0 = timeout)", name, lat, exp_lat);
    end
    if (resp_rdata !== exp_rdata) begin
      errors++; $display("FAIL %s rdata: got %h expected %h", name, resp_rdata, exp_rdata);
    end
    if (resp_err !== exp_err) begin
      errors++; $display("FAIL %s err: got %b expected %b", name, resp_err, exp_err);
    end
    if (we_cnt != exp_we) begin
      errors++; $display("FAIL %s mem_we cycles: got %0d expected %0d", name, we_cnt, exp_we);
    end
    @(negedge clk);
    checks += 3;
    if (resp_valid !== 1'b0) begin
      errors++; $display("FAIL %s pulse: resp_valid still %b", name, resp_valid);
    end
    if (resp_rdata !== exp_rdata) begin
      errors++; $display("FAIL %s rdata hold: got %h expected %h", name, resp_rdata, exp_rdata);
    end
    if (mem[addr[9:2]] !== ref_mem[addr[9:2]]) begin
      errors++; $display("FAIL %s mem word: got %h expected %h", name, mem[addr[9:2]], ref_mem[addr[9:2]]);
    end
  endtask

  task automatic check_reset_outputs(input string name);
    logic [100:0] got;
    got = {req_ready, resp_valid, resp_rdata, resp_err, mem_we, mem_addr, mem_wd};
    checks++;
    if (got !== {1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0}) begin
      errors++;
      $display("FAIL %s: got rdy=%b vld=%b rd=%h err=%b we=%b addr=%h wd=%h expected 1 0 0 0 0 0 0",
               name, req_ready, resp_valid, resp_rdata, resp_err, mem_we, mem_addr, mem_wd);
    end
  endtask

  task automatic test_reset;
    logic [31:0] rd;
    logic        er;
    reset = 1'b1; mem_init = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
    req_signed = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
    for (int i = 0; i < 256; i++) ref_mem[i] = pat(i);
    repeat (3) @(negedge clk);
    check_reset_outputs("reset_initial");
    mem_init = 1'b0; reset = 1'b0;
    run_req(1'b0, 2'b10, 1'b0, 32'h0000_0040, 32'h0, "pre_reset_lw", rd, er);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b00; req_addr = 32'h0000_0041;
    req_wdata = 32'h0000_005A;
    @(posedge clk); #1;
    req_valid = 1'b0;
    reset = 1'b1;
    #1 check_reset_outputs("reset_mid_rmw_immediate");
    @(negedge clk);
    check_reset_outputs("reset_mid_rmw_sample");
    checks++;
    if (mem[16] !== ref_mem[16]) begin
      errors++; $display("FAIL reset_mid_rmw mem: got %h expected %h", mem[16], ref_mem[16]);
    end
    reset = 1'b0;
  endtask

  task automatic test_spec_vectors;
    logic [31:0] rd;
    logic        er;
    run_req(1'b1, 2'b10, 1'b0, 32'h10, 32'h8001_F0A5, "sw_0x10", rd, er);
    run_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, "lw_0x10", rd, er);
    checks++; if (rd !== 32'h8001_F0A5) begin errors++; $display("FAIL lw_0x10 const: got %h expected 8001f0a5", rd); end
    run_req(1'b0, 2'b00, 1'b1, 32'h10, 32'h0, "lb_0x10", rd, er);
    checks++; if (rd !== 32'hFFFF_FFA5) begin errors++; $display("FAIL lb_0x10 const: got %h expected ffffffa5", rd); end
    run_req(1'b0, 2'b00, 1'b0, 32'h11, 32'h0, "lbu_0x11", rd, er);
    checks++; if (rd !== 32'h0000_00F0) begin errors++; $display("FAIL lbu_0x11 const: got %h expected 000000f0", rd); end
    run_req(1'b0, 2'b01, 1'b1, 32'h12, 32'h0, "lh_0x12", rd, er);
    checks++; if (rd !== 32'hFFFF_8001) begin errors++; $display("FAIL lh_0x12 const: got %h expected ffff8001", rd); end
    run_req(1'b0, 2'b01, 1'b0, 32'h12, 32'h0, "lhu_0x12", rd, er);
    checks++; if (rd !== 32'h0000_8001) begin errors++; $display("FAIL lhu_0x12 const: got %h expected 00008001", rd); end
    run_req(1'b1, 2'b00, 1'b0, 32'h13, 32'h0000_00CC, "sb_0x13", rd, er);
    checks++; if (mem[4] !== 32'hCC01_F0A5) begin errors++; $display("FAIL sb_0x13 const: got %h expected cc01f0a5", mem[4]); end
  endtask

  task automatic test_misalign;
    logic [31:0] rd;
    logic        er;
    run_req(1'b0, 2'b10, 1'b0, 32'h12, 32'h0, "lw_0x12", rd, er);
    checks++;
`ifdef MEM_MISALIGN_CHECK_EN
    if (er !== 1'b1 || rd !== 32'h0) begin
      errors++; $display("FAIL lw_0x12 misaligned: got err=%b rd=%h expected err=1 rd=0", er, rd);
    end
`else
    if (er !== 1'b0 || rd !== 32'hCC01_F0A5) begin
      errors++; $display("FAIL lw_0x12 forced: got err=%b rd=%h expected err=0 rd=cc01f0a5", er, rd);
    end
`endif
  endtask

  task automatic test_wrap;
    logic [31:0] rd;
    logic        er;
    run_req(1'b1, 2'b10, 1'b0, 32'hFFFF_FFFC, 32'h1357_9BDF, "sw_top", rd, er);
    run_req(1'b0, 2'b10, 1'b0, 32'hFFFF_FFFC, 32'h0, "lw_top", rd, er);
    run_req(1'b0, 2'b00, 1'b1, 32'hFFFF_FFFF, 32'h0, "lb_top", rd, er);
  endtask

  task automatic test_random;
    logic [31:0] rd;
    logic        er;
    for (int i = 0; i < 40; i++)
      run_req(1'($urandom), 2'($urandom), 1'($urandom), $urandom, $urandom, "random", rd, er);
  endtask

  task automatic test_back_to_back;
    logic [31:0] exp_q [$];
    logic [31:0] base, ed, d_rdata;
    logic        we_a [3];
    logic [1:0]  size_a [3];
    logic        sgn_a [3];
    logic [31:0] addr_a [3], wd_a [3];
    logic        d_err, ready_prev;
    int          cur, got, d_lat, d_we;
    base = $urandom & 32'hFFFF_FFFC;
    we_a[0] = 1'b0; size_a[0] = 2'b10; sgn_a[0] = 1'b0; addr_a[0] = base;
    we_a[1] = 1'b1; size_a[1] = 2'b00; sgn_a[1] = 1'b0; addr_a[1] = base + 32'($urandom_range(3));
    we_a[2] = 1'b0; size_a[2] = 2'b10; sgn_a[2] = 1'b0; addr_a[2] = base;
    for (int i = 0; i < 3; i++) wd_a[i] = $urandom;
    cur = 0; got = 0;
    @(negedge clk);
    req_valid = 1'b1; req_we = we_a[0]; req_size = size_a[0]; req_signed = sgn_a[0];
    req_addr = addr_a[0]; req_wdata = wd_a[0];
    for (int c = 0; c < 40 && got < 3; c++) begin
      ready_prev = req_ready;
      @(negedge clk);
      if (resp_valid === 1'b1) begin
        checks++; got++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL b2b extra response: got %h expected none", resp_rdata);
        end else begin
          ed = exp_q.pop_front();
          if (resp_rdata !== ed) begin
            errors++; $display("FAIL b2b response %0d: got %h expected %h", got, resp_rdata, ed);
          end
        end
      end
      if (req_valid && ready_prev) begin
        model(we_a[cur], size_a[cur], sgn_a[cur], addr_a[cur], wd_a[cur], d_rdata, d_err, d_lat, d_we);
        exp_q.push_back(d_rdata);
        cur++;
        if (cur < 3) begin
          req_we = we_a[cur]; req_size = size_a[cur]; req_signed = sgn_a[cur];
          req_addr = addr_a[cur]; req_wdata = wd_a[cur];
        end else req_valid = 1'b0;
      end
    end
    req_valid = 1'b0;
    checks += 2;
    if (got != 3 || cur != 3) begin
      errors++; $display("FAIL b2b count: got %0d responses %0d accepts expected 3 3", got, cur);
    end
    if (mem[base[9:2]] !== ref_mem[base[9:2]]) begin
      errors++; $display("FAIL b2b mem word: got %h expected %h", mem[base[9:2]], ref_mem[base[9:2]]);
    end
  endtask

  initial begin
    test_reset();
    test_spec_vectors();
    test_misalign();
    test_wrap();
    test_back_to_back();
    test_random();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
